// File: rtl/pipe_ctrl_if.sv
// Hazard/handshake inputs and stall/select outputs between the Beta pipeline and its sequencer.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [5:0]       dec_op;
  logic [4:0]       dec_ra;
  logic [4:0]       dec_rb;
  logic             dec_rb_used;
  logic [4:0]       ex_rc;
  logic             ex_is_load;
  logic             br_taken;
  logic             jmp;
  logic             irq;
  logic             pc_kernel;
  logic             dmem_req;
  logic             dmem_ack;
  logic             clr_err;
  logic             stall_if;
  logic             stall_dec;
  logic             stall_ex;
  logic             stall_mem;
  logic [1:0]       ir_src_if;
  logic [1:0]       ir_src_dec;
  logic [2:0]       pc_sel;
  logic [CNT_W-1:0] stall_cycles;
  logic             mem_err;

  modport master (
    output dec_op, dec_ra, dec_rb, dec_rb_used, ex_rc, ex_is_load, br_taken, jmp,
           irq, pc_kernel, dmem_req, dmem_ack, clr_err,
    input  stall_if, stall_dec, stall_ex, stall_mem, ir_src_if, ir_src_dec, pc_sel,
           stall_cycles, mem_err
  );

  modport slave (
    input  dec_op, dec_ra, dec_rb, dec_rb_used, ex_rc, ex_is_load, br_taken, jmp,
           irq, pc_kernel, dmem_req, dmem_ack, clr_err,
    output stall_if, stall_dec, stall_ex, stall_mem, ir_src_if, ir_src_dec, pc_sel,
           stall_cycles, mem_err
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Beta 5-stage pipeline sequencer: per-cycle stall/annul/inject decisions, stall-cycle
// counter and sticky data-memory timeout flag.
module pipe_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);
  localparam logic [1:0] IR_SRC_DATA   = 2'd0;
  localparam logic [1:0] IR_SRC_NOP    = 2'd1;
  localparam logic [1:0] IR_SRC_EXCEPT = 2'd2;

  localparam logic [2:0] PC_INC    = 3'd0;
  localparam logic [2:0] PC_BRANCH = 3'd1;
  localparam logic [2:0] PC_JUMP   = 3'd2;
  localparam logic [2:0] PC_XADDR  = 3'd3;
  localparam logic [2:0] PC_RESET  = 3'd4;

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_RUN,
    ST_LD_STALL,
    ST_MEM_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

  logic       hazard;
  logic       set_err;
  logic       stall_all;
  logic       stall_if, stall_dec;
  logic [1:0] ir_src_if, ir_src_dec;
  logic [2:0] pc_sel;

  // Opcode is not needed: dec_rb_used already encodes which classes read RB/RC.
  logic unused_dec_op;
  assign unused_dec_op = ^bus.dec_op;

  assign hazard = bus.ex_is_load && (bus.ex_rc != 5'd31) &&
                  ((bus.dec_ra == bus.ex_rc) || (bus.dec_rb_used && (bus.dec_rb == bus.ex_rc)));

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    set_err    = 1'b0;
    stall_all  = 1'b0;
    stall_if   = 1'b0;
    stall_dec  = 1'b0;
    ir_src_if  = IR_SRC_DATA;
    ir_src_dec = IR_SRC_DATA;
    pc_sel     = PC_INC;

    if (state_q == ST_RESET) begin
      pc_sel     = PC_RESET;
      ir_src_if  = IR_SRC_NOP;
      ir_src_dec = IR_SRC_NOP;
      state_d    = ST_RUN;
    end else if ((state_q == ST_MEM_WAIT) && !bus.dmem_ack) begin
      stall_all = 1'b1;
      if (wcnt_q != WCNT_W'(MEM_TIMEOUT)) begin
        wcnt_d = wcnt_q + 1'b1;
      end
      set_err = (wcnt_d == WCNT_W'(MEM_TIMEOUT));
    end else if ((state_q != ST_MEM_WAIT) && bus.dmem_req && !bus.dmem_ack) begin
      stall_all = 1'b1;
      wcnt_d    = '0;
      state_d   = ST_MEM_WAIT;
    end else if (hazard) begin
      stall_if   = 1'b1;
      stall_dec  = 1'b1;
      ir_src_dec = IR_SRC_NOP;
      state_d    = ST_LD_STALL;
    end else begin
      // Covers RUN, the single LD_STALL cycle and the MEM_WAIT ack cycle alike.
      state_d = ST_RUN;
      if (bus.irq && !bus.pc_kernel) begin
        ir_src_dec = IR_SRC_EXCEPT;
        ir_src_if  = IR_SRC_NOP;
        pc_sel     = PC_XADDR;
      end else if (bus.jmp) begin
        pc_sel    = PC_JUMP;
        ir_src_if = IR_SRC_NOP;
      end else if (bus.br_taken) begin
        pc_sel    = PC_BRANCH;
        ir_src_if = IR_SRC_NOP;
      end
    end

    if (stall_all) begin
      stall_if  = 1'b1;
      stall_dec = 1'b1;
    end

    mem_err_d = set_err ? 1'b1 : (bus.clr_err ? 1'b0 : mem_err_q);

    stall_cycles_d = stall_cycles_q;
    if (stall_dec && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RESET;
      wcnt_q         <= '0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      mem_err_q      <= mem_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stall_if     = stall_if;
  assign bus.stall_dec    = stall_dec;
  assign bus.stall_ex     = stall_all;
  assign bus.stall_mem    = stall_all;
  assign bus.ir_src_if    = ir_src_if;
  assign bus.ir_src_dec   = ir_src_dec;
  assign bus.pc_sel       = pc_sel;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.mem_err      = mem_err_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl against a cycle-level behavioural model of the sequencing rules.
module tb_pipe_ctrl;
  localparam int TB_CNT_W = 6;
  localparam int TB_TO    = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
  localparam int NCYC     = 3000;

  localparam int SRC_DATA = 0;
  localparam int SRC_NOP  = 1;
  localparam int SRC_EXC  = 2;

  logic clk;
  logic rst_n;

  pipe_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

  pipe_ctrl #(.CNT_W(TB_CNT_W), .MEM_TIMEOUT(TB_TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  int cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Model state: reset cycle pending, waiting on memory, wait count, error flag, stall count.
  bit m_rst;
  bit m_wait;
  int m_wcnt;
  bit m_err;
  int m_scnt;

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    int e_sif, e_sdec, e_sex, e_smem, e_src_if, e_src_dec, e_pc;
    bit hz, set;
    int ack_pct;

    n_cmp  = 0;
    n_bad  = 0;
    m_rst  = 1;
    m_wait = 0;
    m_wcnt = 0;
    m_err  = 0;
    m_scnt = 0;
    rst_n  = 1'b0;
    {bus.dec_op, bus.dec_ra, bus.dec_rb, bus.dec_rb_used, bus.ex_rc, bus.ex_is_load} = '0;
    {bus.br_taken, bus.jmp, bus.irq, bus.pc_kernel, bus.dmem_req, bus.dmem_ack, bus.clr_err} = '0;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      // Phases alternate between prompt, moderate and very slow memory acknowledgement.
      case ((cyc / 250) % 3)
        0:       ack_pct = 80;
        1:       ack_pct = 35;
        default: ack_pct = 5;
      endcase
      rst_n           = (cyc < 2) ? 1'b0 : ($urandom_range(399) != 0);
      bus.dec_op      = 6'($urandom);
      bus.dec_ra      = pick_reg();
      bus.dec_rb      = pick_reg();
      bus.dec_rb_used = $urandom_range(1);
      bus.ex_rc       = pick_reg();
      bus.ex_is_load  = $urandom_range(1);
      bus.br_taken    = ($urandom_range(3) == 0);
      bus.jmp         = ($urandom_range(3) == 0);
      bus.irq         = ($urandom_range(3) == 0);
      bus.pc_kernel   = $urandom_range(1);
      bus.dmem_req    = ($urandom_range(2) == 0);
      bus.dmem_ack    = ($urandom_range(99) < ack_pct);
      bus.clr_err     = ($urandom_range(9) == 0);
      #2;

      if (!rst_n) begin
        m_rst  = 1;
        m_wait = 0;
        m_wcnt = 0;
        m_err  = 0;
        m_scnt = 0;
      end

      check("stall_cycles", 32'(bus.stall_cycles), 32'(m_scnt));
      check("mem_err", 32'(bus.mem_err), 32'(m_err));

      e_sif = 0; e_sdec = 0; e_sex = 0; e_smem = 0;
      e_src_if = SRC_DATA; e_src_dec = SRC_DATA; e_pc = 0;
      set = 0;
      hz = bus.ex_is_load && (bus.ex_rc != 31) &&
           ((bus.dec_ra == bus.ex_rc) || (bus.dec_rb_used && (bus.dec_rb == bus.ex_rc)));

      if (!rst_n || m_rst) begin
        e_pc = 4; e_src_if = SRC_NOP; e_src_dec = SRC_NOP;
        if (rst_n) m_rst = 0;
      end else if (m_wait && !bus.dmem_ack) begin
        e_sif = 1; e_sdec = 1; e_sex = 1; e_smem = 1;
        m_wcnt++;
        if (m_wcnt >= TB_TO) set = 1;
      end else if (!m_wait && bus.dmem_req && !bus.dmem_ack) begin
        e_sif = 1; e_sdec = 1; e_sex = 1; e_smem = 1;
        m_wait = 1;
        m_wcnt = 0;
      end else begin
        m_wait = 0;
        if (hz) begin
          e_sif = 1; e_sdec = 1; e_src_dec = SRC_NOP;
        end else if (bus.irq && !bus.pc_kernel) begin
          e_src_dec = SRC_EXC; e_src_if = SRC_NOP; e_pc = 3;
        end else if (bus.jmp) begin
          e_pc = 2; e_src_if = SRC_NOP;
        end else if (bus.br_taken) begin
          e_pc = 1; e_src_if = SRC_NOP;
        end
      end

      check("stall_if", 32'(bus.stall_if), 32'(e_sif));
      check("stall_dec", 32'(bus.stall_dec), 32'(e_sdec));
      check("stall_ex", 32'(bus.stall_ex), 32'(e_sex));
      check("stall_mem", 32'(bus.stall_mem), 32'(e_smem));
      check("ir_src_if", 32'(bus.ir_src_if), 32'(e_src_if));
      check("ir_src_dec", 32'(bus.ir_src_dec), 32'(e_src_dec));
      check("pc_sel", 32'(bus.pc_sel), 32'(e_pc));

      if (rst_n) begin
        if (set) m_err = 1;
        else if (bus.clr_err) m_err = 0;
        if (e_sdec == 1 && m_scnt < CNT_MAX) m_scnt++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
